// File: rtl/memory_system.sv
// Byte-addressed memory subsystem: loadable program memory, data RAM, and
// optional memory-mapped I/O ports (enabled by the MEM_IO_PORTS_EN macro).
module memory_system #(
  parameter int LOAD_ON_RESET = 1,
  parameter int PROG_BYTES    = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  address,
  input  logic [7:0]  to_memory,
  input  logic        write,
  output logic [7:0]  from_memory,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  input  logic        load_done,
  output logic        load_ready,
  output logic        cpu_hold,
  output logic [31:0] port_out,
  input  logic [31:0] port_in
);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam state_t     RESET_STATE = (LOAD_ON_RESET != 0) ? LOAD : RUN;
  localparam logic [6:0] LAST_IDX    = 7'(PROG_BYTES - 1);

  logic [7:0]  prog_mem [0:127];
  logic [7:0]  data_mem [0:127];

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        hold_q;
  logic        prog_we;
  logic        cpu_we;
  logic        ram_we;

  logic        is_prog;
  logic        prog_in_range;
  logic        is_ram;
  logic        is_oport;
  logic        is_iport;

  logic [7:0]  rd_data_p0;
  logic [7:0]  rd_data_p1;
  logic [31:0] port_out_q;

  // Address decode
  assign is_prog       = ~address[7];
  assign prog_in_range = int'(address) < PROG_BYTES;

`ifdef MEM_IO_PORTS_EN
  assign is_ram   = address[7] && (address < 8'hE0);
  assign is_oport = (address[7:2] == 6'b111000);
  assign is_iport = (address[7:2] == 6'b111100);
`else
  assign is_ram   = address[7];
  assign is_oport = 1'b0;
  assign is_iport = 1'b0;
`endif

  always_comb begin
    rd_data_p0 = 8'h00;
    if (is_prog) begin
      if (prog_in_range) rd_data_p0 = prog_mem[address[6:0]];
    end else if (is_ram) begin
      rd_data_p0 = data_mem[address[6:0]];
`ifdef MEM_IO_PORTS_EN
    end else if (is_oport) begin
      rd_data_p0 = port_out_q[{address[1:0], 3'b000} +: 8];
    end else if (is_iport) begin
      rd_data_p0 = port_in[{address[1:0], 3'b000} +: 8];
`endif
    end
  end

  // Loader FSM: a byte accepted together with load_done is still written
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prog_we = 1'b0;
    case (state_q)
      LOAD: begin
        if (load_valid) begin
          prog_we = 1'b1;
          cnt_d   = cnt_q + 7'd1;
        end
        if ((load_valid && (cnt_q == LAST_IDX)) || load_done) begin
          state_d = RUN;
          cnt_d   = 7'd0;
        end
      end
      RUN: begin
        if (load_start) begin
          state_d = LOAD;
          cnt_d   = 7'd0;
        end
      end
    endcase
  end

  assign cpu_we = write && (state_q == RUN);
  assign ram_we = cpu_we && is_ram;

  // Stage p0 -> p1: registered read data and control state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      cnt_q      <= 7'd0;
      hold_q     <= (RESET_STATE == LOAD);
      rd_data_p1 <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= (state_d == LOAD);
      rd_data_p1 <= rd_data_p0;
    end
  end

  // Arrays have no reset so an aborted load keeps the bytes already written
  always_ff @(posedge clk) begin
    if (prog_we) prog_mem[cnt_q] <= load_data;
    if (ram_we)  data_mem[address[6:0]] <= to_memory;
  end

`ifdef MEM_IO_PORTS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_out_q <= 32'h0;
    end else if (cpu_we && is_oport) begin
      port_out_q[{address[1:0], 3'b000} +: 8] <= to_memory;
    end
  end
`else
  logic unused_port_in;
  assign unused_port_in = ^{port_in, is_oport, is_iport};
  assign port_out_q     = 32'h0;
`endif

  assign from_memory = rd_data_p1;
  assign load_ready  = hold_q;
  assign cpu_hold    = hold_q;
  assign port_out    = port_out_q;

endmodule

// File: tb/tb_memory_system.sv
// Directed bench for memory_system: load sequences, RUN-mode vector table,
// reset-mid-load, and the I/O map selected by MEM_IO_PORTS_EN.
module tb_memory_system;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  address;
  logic [7:0]  to_memory;
  logic        write;
  logic [7:0]  from_memory;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_done;
  logic        load_ready;
  logic        cpu_hold;
  logic [31:0] port_out;
  logic [31:0] port_in;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic       wr;
    logic [7:0] wdata;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [13];

  memory_system #(.LOAD_ON_RESET(1), .PROG_BYTES(128)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .to_memory   (to_memory),
    .write       (write),
    .from_memory (from_memory),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_done   (load_done),
    .load_ready  (load_ready),
    .cpu_hold    (cpu_hold),
    .port_out    (port_out),
    .port_in     (port_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{addr: 8'h90, wr: 1'b1, wdata: 8'hA5, chk: 1'b0, exp: 8'h00};
    vecs[1]  = '{addr: 8'h90, wr: 1'b0, wdata: 8'h00, chk: 1'b1, exp: 8'hA5};
    vecs[2]  = '{addr: 8'h10, wr: 1'b1, wdata: 8'h33, chk: 1'b1, exp: 8'h20};
    vecs[3]  = '{addr: 8'h10, wr: 1'b0, wdata: 8'h00, chk: 1'b1, exp: 8'h20};
    vecs[4]  = '{addr: 8'h90, wr: 1'b1, wdata: 8'h5A, chk: 1'b1, exp: 8'hA5};
    vecs[5]  = '{addr: 8'h90, wr: 1'b0, wdata: 8'h00, chk: 1'b1, exp: 8'h5A};
    vecs[6]  = '{addr: 8'h81, wr: 1'b1, wdata: 8'h77, chk: 1'b0, exp: 8'h00};
    vecs[7]  = '{addr: 8'h81, wr: 1'b0, wdata: 8'h00, chk: 1'b1, exp: 8'h77};
    vecs[8]  = '{addr: 8'h7F, wr: 1'b0, wdata: 8'h00, chk: 1'b1, exp: 8'h8F};
    vecs[9]  = '{addr: 8'h00, wr: 1'b0, wdata: 8'h00, chk: 1'b1, exp: 8'h10};
    vecs[10] = '{addr: 8'hDF, wr: 1'b1, wdata: 8'h3C, chk: 1'b0, exp: 8'h00};
    vecs[11] = '{addr: 8'hDF, wr: 1'b0, wdata: 8'h00, chk: 1'b1, exp: 8'h3C};
    vecs[12] = '{addr: 8'h90, wr: 1'b0, wdata: 8'h00, chk: 1'b1, exp: 8'h5A};

    reset = 1'b1; address = 8'h00; to_memory = 8'h00; write = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_done = 1'b0;
    port_in = 32'h0;

    #3;
    check("rst_from_memory", {24'h0, from_memory}, 32'h0);
    check("rst_port_out", port_out, 32'h0);
    check("rst_cpu_hold", {31'h0, cpu_hold}, 32'h1);
    check("rst_load_ready", {31'h0, load_ready}, 32'h1);
    tick();
    tick();
    reset = 1'b0;

    // Full 128-byte load
    for (int i = 0; i < 128; i++) begin
      load_valid = 1'b1;
      load_data  = 8'h10 + i[7:0];
      tick();
      if (i == 126) check("hold_mid_load", {31'h0, cpu_hold}, 32'h1);
    end
    load_valid = 1'b0;
    check("hold_after_full_load", {31'h0, cpu_hold}, 32'h0);
    check("ready_after_full_load", {31'h0, load_ready}, 32'h0);
    address = 8'h05;
    tick();
    check("read_prog_05", {24'h0, from_memory}, 32'h15);

    // RUN-mode vector table
    for (int i = 0; i < 13; i++) begin
      address   = vecs[i].addr;
      write     = vecs[i].wr;
      to_memory = vecs[i].wdata;
      tick();
      if (vecs[i].chk) check($sformatf("vec%0d", i), {24'h0, from_memory}, {24'h0, vecs[i].exp});
    end
    write = 1'b0;

`ifdef MEM_IO_PORTS_EN
    address = 8'hE2; to_memory = 8'hC3; write = 1'b1;
    tick();
    write = 1'b0;
    check("port_out_byte2", {24'h0, port_out[23:16]}, 32'hC3);
    check("port_out_word", port_out, 32'h00C3_0000);
    tick();
    check("read_oport_e2", {24'h0, from_memory}, 32'hC3);
    port_in = 32'h0000_007E; address = 8'hF0;
    tick();
    check("read_iport_f0", {24'h0, from_memory}, 32'h7E);
    address = 8'hE8;
    tick();
    check("read_unmapped_e8", {24'h0, from_memory}, 32'h00);
    address = 8'hF4;
    tick();
    check("read_unmapped_f4", {24'h0, from_memory}, 32'h00);
`else
    address = 8'hE2; to_memory = 8'h44; write = 1'b1;
    tick();
    write = 1'b0;
    check("port_out_tied", port_out, 32'h0);
    tick();
    check("read_ram_e2", {24'h0, from_memory}, 32'h44);
    address = 8'hFF; to_memory = 8'h99; write = 1'b1;
    tick();
    write = 1'b0;
    tick();
    check("read_ram_ff", {24'h0, from_memory}, 32'h99);
    check("port_out_still_0", port_out, 32'h0);
`endif

    // load_valid is ignored in RUN
    address = 8'h00; load_valid = 1'b1; load_data = 8'hEE;
    tick();
    load_valid = 1'b0;
    check("run_valid_rd", {24'h0, from_memory}, 32'h10);
    tick();
    check("run_valid_ignored", {24'h0, from_memory}, 32'h10);

    // Short load terminated by load_done on the third byte
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("hold_after_start", {31'h0, cpu_hold}, 32'h1);
    check("ready_after_start", {31'h0, load_ready}, 32'h1);
    address = 8'h90; to_memory = 8'h11; write = 1'b1;
    tick();
    write = 1'b0;
    check("load_write_rd", {24'h0, from_memory}, 32'h5A);
    load_valid = 1'b1; load_data = 8'hA0;
    tick();
    load_data = 8'hA1;
    tick();
    load_data = 8'hA2; load_done = 1'b1;
    tick();
    load_valid = 1'b0; load_done = 1'b0;
    check("hold_after_done", {31'h0, cpu_hold}, 32'h0);
    address = 8'h02;
    tick();
    check("short_load_02", {24'h0, from_memory}, 32'hA2);
    address = 8'h03;
    tick();
    check("short_load_03_old", {24'h0, from_memory}, 32'h13);
    address = 8'h00;
    tick();
    check("short_load_00", {24'h0, from_memory}, 32'hA0);
    address = 8'h90;
    tick();
    check("load_write_ignored", {24'h0, from_memory}, 32'h5A);

    // load_done alone ends LOAD without writing
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check("hold_after_bare_done", {31'h0, cpu_hold}, 32'h0);
    address = 8'h00;
    tick();
    check("bare_done_no_write", {24'h0, from_memory}, 32'hA0);

    // Reset in the middle of a load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    address = 8'h02; load_valid = 1'b1; load_data = 8'hB0;
    tick();
    load_data = 8'hB1;
    tick();
    load_valid = 1'b0;
    check("pre_reset_rd", {24'h0, from_memory}, 32'hA2);
    #1 reset = 1'b1;
    #1;
    check("async_rst_from_memory", {24'h0, from_memory}, 32'h0);
    check("async_rst_port_out", port_out, 32'h0);
    check("async_rst_cpu_hold", {31'h0, cpu_hold}, 32'h1);
    tick();
    reset = 1'b0;
    load_valid = 1'b1; load_data = 8'hC0; load_done = 1'b1;
    tick();
    load_valid = 1'b0; load_done = 1'b0;
    check("hold_after_reload", {31'h0, cpu_hold}, 32'h0);
    address = 8'h00;
    tick();
    check("reload_restart_00", {24'h0, from_memory}, 32'hC0);
    address = 8'h01;
    tick();
    check("reload_kept_01", {24'h0, from_memory}, 32'hB1);
    address = 8'h02;
    tick();
    check("reload_kept_02", {24'h0, from_memory}, 32'hA2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
